mcc_serial_ctrl: RTL and testbench
==================================

MCC_SERIAL_CTRL -- requirements
Module: mcc_serial_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a WIDTH-bit add; sampled only when ready=1.
REQ-005 a  input  WIDTH  operand A, captured on accepted start.
REQ-006 b  input  WIDTH  operand B, captured on accepted start.
REQ-007 cin  input  1  carry-in, captured on accepted start.
REQ-008 ready  output  1  high in IDLE and DONE; start is accepted only then.
REQ-009 busy  output  1  high in RUN.
REQ-010 done  output  1  one-cycle pulse; sum/cout are valid in that cycle.
REQ-011 sum  output  WIDTH  result; held stable from done until the next accepted start.
REQ-012 cout  output  1  carry out of bit WIDTH-1; held with sum.

Function
REQ-013 The block SHALL add a+b+cin bit-serially, LSB first, with one bit per clock through a single 1-bit carry cell.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, encoded in 2 bits.
REQ-015 IDLE or DONE with start=1: capture a, b and cin into shift/carry registers, clear bit counter to 0, clear sum, go to RUN.
REQ-016 DONE with start=0: go to IDLE; sum and cout are retained.
REQ-017 Each RUN cycle SHALL compute bit[counter], shift it into sum from the MSB end, register the carry, and increment the counter.
REQ-018 RUN SHALL exit to DONE after the cycle in which counter==WIDTH-1; the counter SHALL never wrap inside RUN.
REQ-019 Latency: start accepted at edge T gives done=1 in the cycle after edge T+WIDTH, i.e. WIDTH+1 edges from start to done.
REQ-020 start while busy=1 SHALL be ignored, with no effect on operands or result.
REQ-021 start in the DONE cycle SHALL be accepted, giving back-to-back operations with no IDLE cycle between them.
REQ-022 Input changes on a, b or cin after capture SHALL NOT affect the result in flight.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force: state IDLE, counter 0, sum 0, cout 0, done 0, busy 0, ready 1.
REQ-024 Reset during RUN SHALL abort the operation, producing no done pulse and no partial sum on the outputs.
REQ-025 start sampled in the same edge as rst_n=0 SHALL be ignored.

Configuration
REQ-026 Macro MCC_SERIAL_OVF_EN defined: add output port ovf (1 bit) = carry into bit WIDTH-1 XOR cout, valid and held like sum, and reset to 0.
REQ-027 Macro undefined: port ovf and its carry-snapshot register SHALL be absent; all other behaviour is unchanged.

Structure
REQ-028 Shared package mcc_pkg SHALL hold the FSM state encoding constants (IDLE=0, RUN=1, DONE=2) and MCC_DEFAULT_WIDTH=8.
REQ-029 One sub-module, mcc_bit_step, SHALL be a combinational 1-bit full add (inputs a_i, b_i, c_i; outputs s_o, c_o) instantiated once.
REQ-030 The carry register, operand shift registers and counter SHALL live in mcc_serial_ctrl; mcc_bit_step SHALL contain no state.

Verification
REQ-031 WIDTH=8: a=0x00, b=0x00, cin=0, start pulse -> done after 9 edges, sum=0x00, cout=0, busy high for 8 cycles.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with MCC_SERIAL_OVF_EN, ovf=0.
REQ-033 a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0; with MCC_SERIAL_OVF_EN, ovf=1.
REQ-034 Start a=0x12/b=0x34; pulse start with a=0xFF during RUN -> result 0x46, exactly one done pulse.
REQ-035 Assert start in the DONE cycle with a=0x01, b=0x01 -> second done 9 edges later, sum=0x02, first sum 0x46 visible until that capture.
REQ-036 rst_n=0 at the 4th RUN cycle -> next cycle ready=1, sum=0, no done; a fresh add of 0xAA+0x55+1 -> sum=0x00, cout=1.

Source files
------------

// File: rtl/mcc_pkg.sv
// mcc_pkg: shared constants for the bit-serial adder controller.
//   MCC_DEFAULT_WIDTH  default operand width
//   mcc_state_e        2-bit FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   mcc_cnt_w()        bit-counter width for a given operand width
package mcc_pkg;

  localparam int unsigned MCC_DEFAULT_WIDTH = 8;
  localparam int unsigned MCC_STATE_W       = 2;

  typedef enum logic [MCC_STATE_W-1:0] {
    MCC_IDLE = 2'd0,
    MCC_RUN  = 2'd1,
    MCC_DONE = 2'd2
  } mcc_state_e;

  // Counter must index bits 0..width-1; never narrower than one bit
  function automatic int unsigned mcc_cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mcc_serial_ctrl_if.sv
// mcc_serial_ctrl_if: request/result bundle of the bit-serial adder.
//   start, a, b, cin     request side (driven by master)
//   ready, busy, done    handshake status (driven by slave)
//   sum, cout            result, held from done until next accepted start
//   ovf                  signed overflow, only when MCC_SERIAL_OVF_EN is defined
interface mcc_serial_ctrl_if
  import mcc_pkg::*;
#(
  parameter int unsigned WIDTH = MCC_DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef MCC_SERIAL_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
`ifdef MCC_SERIAL_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
`ifdef MCC_SERIAL_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/mcc_bit_step.sv
// mcc_bit_step: stateless 1-bit full adder used as the serial carry cell.
//   a_i, b_i, c_i  operand bits and carry-in
//   s_o, c_o       sum bit and carry-out
module mcc_bit_step (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/mcc_serial_ctrl.sv
// mcc_serial_ctrl: adds a+b+cin one bit per clock, LSB first.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    mcc_serial_ctrl_if.slave (start/a/b/cin in; ready/busy/done/sum/cout out)
// Optional macro MCC_SERIAL_OVF_EN adds bus.ovf (signed overflow of the result).
module mcc_serial_ctrl
  import mcc_pkg::*;
#(
  parameter int unsigned WIDTH = MCC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  mcc_serial_ctrl_if.slave bus
);

  localparam int unsigned      CNT_W    = mcc_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mcc_state_e       r_state;
  mcc_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_ready_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_s;
  logic             w_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= MCC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MCC_IDLE: if (bus.start) w_state_nxt = MCC_RUN;
      MCC_RUN:  if (r_cnt == CNT_LAST) w_state_nxt = MCC_DONE;
      MCC_DONE: w_state_nxt = bus.start ? MCC_RUN : MCC_IDLE;
      default:  w_state_nxt = MCC_IDLE;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    w_ready_nxt = 1'b1;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      MCC_IDLE, MCC_DONE: w_accept = bus.start;
      MCC_RUN: begin
        w_step = 1'b1;
        w_last = (r_cnt == CNT_LAST);
      end
      default: ;
    endcase
    // Status flags are registered from the state being entered, so they line up with it
    case (w_state_nxt)
      MCC_RUN: begin
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b1;
      end
      MCC_DONE: w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Status flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Single carry cell fed by the operand LSBs
  mcc_bit_step u_bit_step (
    .a_i (r_a[0]),
    .b_i (r_b[0]),
    .c_i (r_carry),
    .s_o (w_s),
    .c_o (w_c)
  );

  // Operand shifters, sum accumulator, carry and bit counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.cin;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
    end else if (w_step) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_c;
      // Counter parks at the last index instead of wrapping
      if (w_last) begin
        r_cout <= w_c;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef MCC_SERIAL_OVF_EN
  logic r_ovf;

  // Carry into the MSB is r_carry during the last step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_step && w_last) begin
      r_ovf <= r_carry ^ w_c;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.sum   = r_sum;
  assign bus.cout  = r_cout;

endmodule

// File: tb/tb_mcc_serial_ctrl.sv
// tb_mcc_serial_ctrl: self-checking bench for mcc_serial_ctrl (WIDTH=8).
// Fixed vectors with hand-derived results, directed back-to-back and reset-abort
// sequences, then random operations compared against an arithmetic model.
module tb_mcc_serial_ctrl;
  import mcc_pkg::*;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  mcc_serial_ctrl_if #(.WIDTH(W)) bus ();

  mcc_serial_ctrl #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got 0x%0h expected 0x%0h", name, tag, act, exp);
    end
  endtask

  // Reference: plain integer addition; signed overflow from operand/result signs
  function automatic logic [W+1:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin);
    logic [W:0] t;
    logic       ovf;
    t   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {ovf, t};
  endfunction

  // Issue one add; returns in the done cycle with results checked
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf, input bit noise, input int tag);
    int edges;
    int busy_cnt;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    tick();
    bus.start = 1'b0;
    check("capture_busy", tag, 32'(bus.busy), 32'd1);
    check("capture_sum_clear", tag, 32'(bus.sum), 32'd0);
    edges    = 1;
    busy_cnt = bus.busy ? 1 : 0;
    while (!bus.done && edges < 40) begin
      if (noise) begin
        bus.start = (edges == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.a     = (edges == 1) ? 8'hFF : W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom_range(0, 1));
      end
      tick();
      edges++;
      if (bus.busy) busy_cnt++;
    end
    bus.start = 1'b0;
    check("done", tag, 32'(bus.done), 32'd1);
    check("latency", tag, 32'(edges), 32'(W + 1));
    check("busy_cycles", tag, 32'(busy_cnt), 32'(W));
    check("ready_in_done", tag, 32'(bus.ready), 32'd1);
    check("sum", tag, 32'(bus.sum), 32'(exp_sum));
    check("cout", tag, 32'(bus.cout), 32'(exp_cout));
`ifdef MCC_SERIAL_OVF_EN
    check("ovf", tag, 32'(bus.ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("note: unknown ovf expectation");
`endif
  endtask

  // One cycle after done: pulse gone, result held, back in IDLE
  task automatic post_check(input logic [W-1:0] exp_sum, input logic exp_cout, input int tag);
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.cin = 1'($urandom_range(0, 1));
    tick();
    check("done_single_pulse", tag, 32'(bus.done), 32'd0);
    check("idle_ready", tag, 32'(bus.ready), 32'd1);
    check("idle_busy", tag, 32'(bus.busy), 32'd0);
    check("sum_hold", tag, 32'(bus.sum), 32'(exp_sum));
    check("cout_hold", tag, 32'(bus.cout), 32'(exp_cout));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int           ndone;

    vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h12, b: 8'h34, cin: 1'b0, sum: 8'h46, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[6] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
    vecs[7] = '{a: 8'h40, b: 8'h40, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};

    // Reset with start held high: start must be ignored
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'hA5;
    bus.cin   = 1'b1;
    repeat (3) tick();
    check("rst_ready", 0, 32'(bus.ready), 32'd1);
    check("rst_busy", 0, 32'(bus.busy), 32'd0);
    check("rst_done", 0, 32'(bus.done), 32'd0);
    check("rst_sum", 0, 32'(bus.sum), 32'd0);
    check("rst_cout", 0, 32'(bus.cout), 32'd0);
`ifdef MCC_SERIAL_OVF_EN
    check("rst_ovf", 0, 32'(bus.ovf), 32'd0);
`endif
    rst_n     = 1'b1;
    bus.start = 1'b0;
    tick();
    check("idle_after_rst", 0, 32'(bus.busy), 32'd0);

    // Table vectors; odd entries run with start/operand noise during RUN
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
             (i % 2) == 1, 100 + i);
      post_check(vecs[i].sum, vecs[i].cout, 100 + i);
      tick();
      check("idle_hold_sum", 100 + i, 32'(bus.sum), 32'(vecs[i].sum));
    end

    // 0x12+0x34 with a start/0xFF pulse mid-RUN, then back-to-back 0x01+0x01
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1, 200);
    check("first_sum_visible", 200, 32'(bus.sum), 32'h46);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 201);
    post_check(8'h02, 1'b0, 201);

    // Reset during the 4th RUN cycle aborts the add
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    check("abort_busy_before", 300, 32'(bus.busy), 32'd1);
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'h0F;
    tick();
    check("abort_ready", 300, 32'(bus.ready), 32'd1);
    check("abort_busy", 300, 32'(bus.busy), 32'd0);
    check("abort_done", 300, 32'(bus.done), 32'd0);
    check("abort_sum", 300, 32'(bus.sum), 32'd0);
    check("abort_cout", 300, 32'(bus.cout), 32'd0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    ndone     = 0;
    repeat (W + 4) begin
      tick();
      if (bus.done) ndone++;
    end
    check("abort_no_done", 300, 32'(ndone), 32'd0);
    check("abort_sum_after", 300, 32'(bus.sum), 32'd0);
    run_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 301);
    post_check(8'h00, 1'b1, 301);

    // Random operations against the model, randomly chained or separated by IDLE
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      m  = model_add(ra, rb, rc);
      run_op(ra, rb, rc, m[W-1:0], m[W], m[W+1], ($urandom_range(0, 1) == 1), 400 + i);
      if ($urandom_range(0, 1) == 1) post_check(m[W-1:0], m[W], 400 + i);
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
